// File: rtl/shifter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shifter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;
    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

endpackage

// File: rtl/shifter_arbiter_if.sv
// Request/result bundle between two shift requesters, the arbiter and its consumer.
interface shifter_arbiter_if #(
    parameter int W   = 32,
    parameter int SHW = 5
);
    logic           AValid, AReady, ADir, AArith;
    logic [W-1:0]   AIn1;
    logic [SHW-1:0] AIn2;
    logic           BValid, BReady, BDir, BArith;
    logic [W-1:0]   BIn1;
    logic [SHW-1:0] BIn2;
    logic           OValid, OReady, OTag, Busy;
    logic [W-1:0]   Out;

    modport slave (
        input  AValid, AIn1, AIn2, ADir, AArith,
        input  BValid, BIn1, BIn2, BDir, BArith,
        input  OReady,
        output AReady, BReady, OValid, Out, OTag, Busy
    );

    modport master (
        output AValid, AIn1, AIn2, ADir, AArith,
        output BValid, BIn1, BIn2, BDir, BArith,
        output OReady,
        input  AReady, BReady, OValid, Out, OTag, Busy
    );
endinterface

// File: rtl/shift_core.sv
// Combinational log shifter; left shifts reuse the right-shift stages via bit reversal.
// SHIFTER_ARITH_EN adds sign fill for arithmetic right shifts.
module shift_core import shifter_pkg::*; #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic [W-1:0]   in_i,
    input  logic [SHW-1:0] amt_i,
    input  logic           dir_i,
`ifdef SHIFTER_ARITH_EN
    input  logic           arith_i,
`endif
    output logic [W-1:0]   res_o
);
    logic [W-1:0] stg [SHW+1];
    logic [W-1:0] rev_in, rev_out;
    logic         fill;

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign rev_in[i]  = in_i[W-1-i];
        assign rev_out[i] = stg[SHW][W-1-i];
    end

`ifdef SHIFTER_ARITH_EN
    assign fill = arith_i && (dir_i == DIR_R) && in_i[W-1];
`else
    assign fill = 1'b0;
`endif

    assign stg[0] = (dir_i == DIR_L) ? rev_in : in_i;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign stg[s+1] = amt_i[s] ? {{SH{fill}}, stg[s][W-1:SH]} : stg[s];
    end

    assign res_o = (dir_i == DIR_L) ? rev_out : stg[SHW];
endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter between two shift requesters feeding one registered shifter result.
// Define SHIFTER_ARITH_EN to enable arithmetic right shifts.
module shifter_arbiter import shifter_pkg::*; #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input logic           Clk,
    input logic           Rst,
    shifter_arbiter_if.slave bus
);
    state_e         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic           tag_q, tag_d, last_q, last_d;
    logic           win, a_rdy, b_rdy, accept, sel;
    logic [W-1:0]   op_in, res;
    logic [SHW-1:0] op_amt;
    logic           op_dir;

    // A new request may enter whenever the output register is free or being drained.
    assign win    = !Rst && ((state_q == IDLE) || bus.OReady);
    assign a_rdy  = win && bus.AValid && (!bus.BValid || (last_q == TAG_B));
    assign b_rdy  = win && bus.BValid && (!bus.AValid || (last_q == TAG_A));
    assign accept = a_rdy || b_rdy;
    assign sel    = b_rdy ? TAG_B : TAG_A;

    assign op_in  = (sel == TAG_B) ? bus.BIn1 : bus.AIn1;
    assign op_amt = (sel == TAG_B) ? bus.BIn2 : bus.AIn2;
    assign op_dir = (sel == TAG_B) ? bus.BDir : bus.ADir;

`ifdef SHIFTER_ARITH_EN
    logic op_arith;
    assign op_arith = (sel == TAG_B) ? bus.BArith : bus.AArith;
`endif

    shift_core #(.W(W), .SHW(SHW)) u_core (
        .in_i    (op_in),
        .amt_i   (op_amt),
        .dir_i   (op_dir),
`ifdef SHIFTER_ARITH_EN
        .arith_i (op_arith),
`endif
        .res_o   (res)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        tag_d   = tag_q;
        last_d  = last_q;
        if (accept) begin
            state_d = HOLD;
            out_d   = res;
            tag_d   = sel;
            last_d  = sel;
        end else if ((state_q == HOLD) && bus.OReady) begin
            state_d = IDLE;
        end
    end

    // Last resets to B so that A wins the first tie.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            tag_q   <= TAG_A;
            last_q  <= TAG_B;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
        end
    end

    assign bus.AReady = a_rdy;
    assign bus.BReady = b_rdy;
    assign bus.OValid = (state_q == HOLD);
    assign bus.Out    = out_q;
    assign bus.OTag   = tag_q;
    assign bus.Busy   = (state_q == HOLD) && !bus.OReady;
endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed self-checking bench for shifter_arbiter with hand-computed expectations.
module tb_shifter_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef SHIFTER_ARITH_EN
    localparam logic [31:0] ARITH_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ARITH_EXP = 32'h0000_0001;
`endif

    shifter_arbiter_if #(.W(32), .SHW(5)) bus ();

    shifter_arbiter #(.W(32), .SHW(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req_a(input logic v, input logic [31:0] d, input logic [4:0] s,
                         input logic dir, input logic ar);
        bus.AValid = v; bus.AIn1 = d; bus.AIn2 = s; bus.ADir = dir; bus.AArith = ar;
    endtask

    task automatic req_b(input logic v, input logic [31:0] d, input logic [4:0] s,
                         input logic dir, input logic ar);
        bus.BValid = v; bus.BIn1 = d; bus.BIn2 = s; bus.BDir = dir; bus.BArith = ar;
    endtask

    // back-to-back A vectors: operand, amount, dir, arith, expected
    logic [31:0] v_in  [4] = '{32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    logic [4:0]  v_sh  [4] = '{5'd0, 5'd4, 5'd31, 5'd16};
    logic        v_dir [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] v_exp [4] = '{32'hDEAD_BEEF, 32'h0800_0000, 32'h8000_0000, 32'h0000_FFFF};

    initial begin
        req_a(1'b1, 32'h1, 5'd1, 1'b0, 1'b0);
        req_b(1'b1, 32'h1, 5'd1, 1'b0, 1'b0);
        bus.OReady = 1'b1;
        tick(); tick();
        chk("rst_aready", bus.AReady, 1'b0);
        chk("rst_bready", bus.BReady, 1'b0);
        chk("rst_ovalid", bus.OValid, 1'b0);
        chk("rst_out", bus.Out, 32'h0);
        chk("rst_otag", bus.OTag, 1'b0);
        chk("rst_busy", bus.Busy, 1'b0);

        // single A request, 1-cycle latency
        Rst = 1'b0;
        req_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        req_a(1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b0);
        #1;
        chk("a_only_aready", bus.AReady, 1'b1);
        chk("a_only_bready", bus.BReady, 1'b0);
        tick();
        req_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("a_only_ovalid", bus.OValid, 1'b1);
        chk("a_only_out", bus.Out, 32'h0000_0F00);
        chk("a_only_otag", bus.OTag, 1'b0);

        // round robin after a fresh reset: A, B, A
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        req_a(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
        req_b(1'b1, 32'h0000_0100, 5'd4, 1'b1, 1'b0);
        #1;
        chk("rr1_ready", {bus.AReady, bus.BReady}, 2'b10);
        tick();
        chk("rr1_tag", bus.OTag, 1'b0);
        chk("rr1_out", bus.Out, 32'h2);
        chk("rr2_ready", {bus.AReady, bus.BReady}, 2'b01);
        tick();
        chk("rr2_tag", bus.OTag, 1'b1);
        chk("rr2_out", bus.Out, 32'h10);
        chk("rr3_ready", {bus.AReady, bus.BReady}, 2'b10);
        tick();
        chk("rr3_tag", bus.OTag, 1'b0);
        chk("rr3_out", bus.Out, 32'h2);
        req_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        req_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("drain_ovalid", bus.OValid, 1'b0);
        chk("drain_out_kept", bus.Out, 32'h2);
        tick();
        chk("no_valid_no_grant", bus.OValid, 1'b0);

        // stall: B held while A waits
        bus.OReady = 1'b0;
        req_b(1'b1, 32'hABCD_0000, 5'd8, 1'b1, 1'b0);
        #1;
        chk("stall_bready", bus.BReady, 1'b1);
        tick();
        req_b(1'b1, 32'h1234_5678, 5'd3, 1'b0, 1'b0);
        req_a(1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_aready", bus.AReady, 1'b0);
            chk("stall_bready_hold", bus.BReady, 1'b0);
            chk("stall_busy", bus.Busy, 1'b1);
            chk("stall_out", bus.Out, 32'h00AB_CD00);
            chk("stall_tag", bus.OTag, 1'b1);
            tick();
        end
        req_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        bus.OReady = 1'b1;
        #1;
        chk("release_aready", bus.AReady, 1'b1);
        chk("release_busy", bus.Busy, 1'b0);
        tick();
        chk("release_out", bus.Out, 32'h0000_000C);
        chk("release_tag", bus.OTag, 1'b0);
        req_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

        // sign-fill right shift from B
        req_b(1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b1);
        #1;
        chk("arith_bready", bus.BReady, 1'b1);
        tick();
        req_b(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("arith_out", bus.Out, ARITH_EXP);

        // back-to-back A, full throughput
        for (int i = 0; i < 4; i++) begin
            req_a(1'b1, v_in[i], v_sh[i], v_dir[i], 1'b0);
            #1;
            chk("b2b_aready", bus.AReady, 1'b1);
            tick();
            chk("b2b_ovalid", bus.OValid, 1'b1);
            chk("b2b_out", bus.Out, v_exp[i]);
        end
        req_a(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        bus.OReady = 1'b0;
        tick();
        chk("hold_before_rst", bus.OValid, 1'b1);

        // reset while holding discards result and restores A priority
        Rst = 1'b1;
        tick();
        chk("rst_hold_ovalid", bus.OValid, 1'b0);
        chk("rst_hold_out", bus.Out, 32'h0);
        Rst = 1'b0;
        bus.OReady = 1'b1;
        req_a(1'b1, 32'h0000_0010, 5'd4, 1'b1, 1'b0);
        req_b(1'b1, 32'h0000_0010, 5'd4, 1'b0, 1'b0);
        #1;
        chk("post_rst_tie", {bus.AReady, bus.BReady}, 2'b10);
        tick();
        chk("post_rst_tag", bus.OTag, 1'b0);
        chk("post_rst_out", bus.Out, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
